// File: rtl/tone_sched_pkg.sv
// Shared types and constants for the memory-game tone scheduler.
// Effect jingles live here so the sequencer stays pattern-agnostic.
package tone_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NOTE,
        ST_GAP,
        ST_ECHO,
        ST_FX
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PB   = 2'd1,
        OWN_KEY  = 2'd2,
        OWN_FX   = 2'd3
    } owner_t;

    localparam logic [3:0] NOTE_SILENT = 4'd0;

    localparam int unsigned MISS_LEN  = 3;
    localparam int unsigned WIN_LEN   = 4;
    localparam int unsigned FX_STEP_W = 2;

    // Miss = {1,0,1}, win = {1,3,5,8}; out-of-range steps are silent.
    function automatic logic [3:0] fx_note(input logic win, input logic [FX_STEP_W-1:0] step);
        logic [3:0] n;
        case ({win, step})
            3'b0_00: n = 4'd1;
            3'b0_01: n = 4'd0;
            3'b0_10: n = 4'd1;
            3'b1_00: n = 4'd1;
            3'b1_01: n = 4'd3;
            3'b1_10: n = 4'd5;
            3'b1_11: n = 4'd8;
            default: n = NOTE_SILENT;
        endcase
        return n;
    endfunction

    function automatic logic [FX_STEP_W-1:0] fx_last(input logic win);
        return win ? FX_STEP_W'(WIN_LEN - 1) : FX_STEP_W'(MISS_LEN - 1);
    endfunction

endpackage

// File: rtl/tone_scheduler_tick_prescaler.sv
// Restartable clock divider: one-cycle tick every TICK_DIV enabled clocks.
// Restart zeroes the phase so a new state always gets a full first tick.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick_c = enable && !restart && (cnt == CNT_LAST);

endmodule

// File: rtl/tone_scheduler.sv
// Arbitrates piezo/LED note outputs among effects, keypad echo and playback,
// and times playback notes (note then gap) and effect steps in ticks.
module tone_scheduler
    import tone_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned NOTE_TICKS = 300,
    parameter int unsigned GAP_TICKS  = 100,
    parameter int unsigned FX_TICKS   = 150
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pb_valid,
    input  logic [3:0] pb_note,
    output logic       pb_ready,
    output logic       pb_done,
    input  logic       key_down,
    input  logic [3:0] key_note,
    input  logic       fx_req,
    input  logic       fx_sel,
    output logic       fx_done,
    output logic [3:0] piezo_out,
    output logic [3:0] led_out,
    output logic [1:0] owner,
    output logic       busy
);

    localparam int unsigned MAX_NG    = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_NG > FX_TICKS) ? MAX_NG : FX_TICKS;
    localparam int unsigned TCNT_W    = $clog2(MAX_TICKS + 1);

    localparam logic [TCNT_W-1:0] NOTE_LAST = TCNT_W'(NOTE_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'(GAP_TICKS - 1);
    localparam logic [TCNT_W-1:0] FX_LAST   = TCNT_W'(FX_TICKS - 1);

    state_t                 state;
    logic [TCNT_W-1:0]      tcnt;
    logic [FX_STEP_W-1:0]   fx_step;
    logic                   fx_win;
    logic                   tick_c;
    logic                   restart_c;
    logic                   enable_c;
    logic [TCNT_W-1:0]      phase_last_c;
    logic                   phase_end_c;

    // Divider idles in IDLE/ECHO and is cleared on the edge that aborts into FX.
    assign restart_c = (state == ST_IDLE) || (state == ST_ECHO) ||
                       (fx_req && ((state == ST_NOTE) || (state == ST_GAP)));
    assign enable_c  = (state == ST_NOTE) || (state == ST_GAP) || (state == ST_FX);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (restart_c),
        .enable  (enable_c),
        .tick_c  (tick_c)
    );

    always_comb begin
        phase_last_c = FX_LAST;
        case (state)
            ST_NOTE: phase_last_c = NOTE_LAST;
            ST_GAP:  phase_last_c = GAP_LAST;
            default: phase_last_c = FX_LAST;
        endcase
    end

    assign phase_end_c = tick_c && (tcnt == phase_last_c);
    assign pb_ready    = (state == ST_IDLE) && !fx_req && !key_down;
    assign led_out     = piezo_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            fx_step   <= '0;
            fx_win    <= 1'b0;
            piezo_out <= NOTE_SILENT;
            owner     <= OWN_NONE;
            busy      <= 1'b0;
            pb_done   <= 1'b0;
            fx_done   <= 1'b0;
        end else begin
            pb_done <= 1'b0;
            fx_done <= 1'b0;
            if (tick_c) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    tcnt <= '0;
                    if (fx_req) begin
                        state     <= ST_FX;
                        fx_step   <= '0;
                        fx_win    <= fx_sel;
                        piezo_out <= fx_note(fx_sel, '0);
                        owner     <= OWN_FX;
                        busy      <= 1'b1;
                    end else if (key_down) begin
                        state     <= ST_ECHO;
                        piezo_out <= key_note;
                        owner     <= OWN_KEY;
                        busy      <= 1'b1;
                    end else if (pb_valid) begin
                        state     <= ST_NOTE;
                        piezo_out <= pb_note;
                        owner     <= OWN_PB;
                        busy      <= 1'b1;
                    end
                end
                ST_NOTE, ST_GAP: begin
                    // Effects abort playback; the dropped note never reports done.
                    if (fx_req) begin
                        state     <= ST_FX;
                        tcnt      <= '0;
                        fx_step   <= '0;
                        fx_win    <= fx_sel;
                        piezo_out <= fx_note(fx_sel, '0);
                        owner     <= OWN_FX;
                    end else if (phase_end_c) begin
                        tcnt      <= '0;
                        piezo_out <= NOTE_SILENT;
                        if (state == ST_NOTE) begin
                            state <= ST_GAP;
                        end else begin
                            state   <= ST_IDLE;
                            owner   <= OWN_NONE;
                            busy    <= 1'b0;
                            pb_done <= 1'b1;
                        end
                    end
                end
                ST_ECHO: begin
                    tcnt <= '0;
                    if (fx_req) begin
                        state     <= ST_FX;
                        fx_step   <= '0;
                        fx_win    <= fx_sel;
                        piezo_out <= fx_note(fx_sel, '0);
                        owner     <= OWN_FX;
                    end else if (!key_down) begin
                        state     <= ST_IDLE;
                        piezo_out <= NOTE_SILENT;
                        owner     <= OWN_NONE;
                        busy      <= 1'b0;
                    end else begin
                        piezo_out <= key_note;
                    end
                end
                ST_FX: begin
                    if (phase_end_c) begin
                        tcnt <= '0;
                        if (fx_step == fx_last(fx_win)) begin
                            state     <= ST_IDLE;
                            piezo_out <= NOTE_SILENT;
                            owner     <= OWN_NONE;
                            busy      <= 1'b0;
                            fx_done   <= 1'b1;
                        end else begin
                            fx_step   <= fx_step + FX_STEP_W'(1);
                            piezo_out <= fx_note(fx_win, fx_step + FX_STEP_W'(1));
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    tcnt      <= '0;
                    piezo_out <= NOTE_SILENT;
                    owner     <= OWN_NONE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Owns the shared piezo/LED note outputs of the memory game and arbitrates them among three requesters: melody playback (note stream), keypad echo (live key), and feedback effects (miss/win jingles). It also sequences note timing (note on, then gap) with an internal restartable tick divider, so the game controller only issues note codes and handshakes. It sits between the game controller/keypad front end and the piezo driver and LED bank.

## Interface
- TICK_DIV, 50000, clocks per tick (1 ms at 50 MHz); ≥1
- NOTE_TICKS, 300, ticks a playback note sounds; ≥1
- GAP_TICKS, 100, ticks of silence after each playback note; ≥1
- FX_TICKS, 150, ticks per effect step; ≥1

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pb_valid  in  1  playback note offered
- pb_note  in  4  playback note code (0 = rest)
- pb_ready  out  1  playback note accepted this edge if pb_valid
- pb_done  out  1  one-cycle pulse when a note's gap completes
- key_down  in  1  keypad key held (level)
- key_note  in  4  note of held key
- fx_req  in  1  effect request (sampled level)
- fx_sel  in  1  0 = miss, 1 = win
- fx_done  out  1  one-cycle pulse at end of effect
- piezo_out  out  4  note to piezo driver (0 = silent)
- led_out  out  4  identical to piezo_out
- owner  out  2  0 none, 1 playback, 2 keypad, 3 effect
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, NOTE, GAP, ECHO, FX. All outputs registered except pb_ready.
- Priority: fx > key > playback, evaluated in IDLE. pb_ready = (state==IDLE) && !fx_req && !key_down.
- IDLE: fx_req → FX (step 0, pattern per fx_sel); else key_down → ECHO; else pb_valid → NOTE with piezo_out ← pb_note.
- NOTE: hold note for NOTE_TICKS, then GAP with outputs 0. GAP: GAP_TICKS, then IDLE with pb_done pulse on the same edge.
- key_down in NOTE/GAP is ignored (no echo during playback).
- fx_req in NOTE/GAP: abort on the next edge, enter FX; aborted note is dropped, no pb_done.
- ECHO: piezo_out ← key_note each cycle (tracks changes, one-cycle lag). key_down low → IDLE, outputs 0. fx_req in ECHO preempts → FX.
- FX: steps from package pattern, each FX_TICKS. Miss = {1,0,1}. Win = {1,3,5,8}. After last step → IDLE, outputs 0, fx_done pulse. fx_req/fx_sel ignored while in FX; fx_sel latched at entry.
- owner reflects state: NOTE/GAP = 1, ECHO = 2, FX = 3, IDLE = 0.
- Reset (any time, including mid-note): state IDLE, piezo_out/led_out = 0, owner = 0, busy = 0, pb_done = fx_done = 0, divider and timers = 0.

## Timing
- Tick divider restarts to 0 on every state entry and FX step entry. One tick = TICK_DIV clocks exactly.
- NOTE lasts exactly NOTE_TICKS·TICK_DIV cycles, GAP exactly GAP_TICKS·TICK_DIV, each FX step exactly FX_TICKS·TICK_DIV.
- Latency from accept edge to piezo_out = pb_note: 0 (updates on the accepting edge).
- Back-to-back playback: after pb_done, IDLE for ≥1 cycle, then next accept.
- Tick counter width: clog2(max(NOTE_TICKS, GAP_TICKS, FX_TICKS)+1). Divider width: clog2(TICK_DIV). No wrap occurs within a phase.

## Structure
- Package tone_sched_pkg: state enum, owner codes, FX pattern constants and lengths (miss 3, win 4), note code 0 = silence.
- Sub-module tick_prescaler: restartable divider with inputs restart/enable and output tick pulse, parameter TICK_DIV.

## Test plan
Parameters for all scenarios: TICK_DIV=4, NOTE_TICKS=3, GAP_TICKS=2, FX_TICKS=2.
- pb_valid with note 5 in IDLE → accepted that edge; piezo=led=5 and owner=1 for 12 cycles; then 0 for 8 cycles; pb_done pulses once; owner=0.
- Stream notes 1,2,3 with pb_valid held → exactly three pb_done pulses, 1-cycle IDLE between notes, order preserved; rest note 0 keeps output silent for 12 cycles.
- key_down with note 7 in IDLE → piezo=7, owner=2; change to 4 → piezo=4 next cycle; release → 0 next cycle. key_down during NOTE → ignored.
- fx_req (miss) at cycle 5 of a note → next edge piezo=1, owner=3; pattern 1,0,1 at 8 cycles each; fx_done; no pb_done for the aborted note.
- Simultaneous fx_req (win), key_down, and pb_valid in IDLE → pb_ready=0; FX plays 1,3,5,8; then ECHO if key still held.
- reset asserted mid-GAP → all outputs 0 immediately, IDLE; the next pb_valid is accepted the first edge after reset deasserts.
